// File: rtl/result_reader.sv
// Snapshots NUM result registers on Start and streams them out one word at a
// time over a valid/ready handshake, pulsing Done after the last word is taken.
module result_reader #(
  parameter int WIDTH = 8,
  parameter int NUM   = 3
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   Start,
  input  logic [NUM*WIDTH-1:0]   Data_in,
  output logic [WIDTH-1:0]       Out_data,
  output logic [3:0]             Out_index,
  output logic                   Out_valid,
  input  logic                   Out_ready,
  output logic                   Busy,
  output logic                   Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] LAST_IDX = 4'(NUM - 1);

  state_e                 state_q, state_d;
  logic [3:0]             index_q, index_d;
  logic [NUM*WIDTH-1:0]   shadow_q, shadow_d;
  logic [WIDTH-1:0]       out_data_q, out_data_d;
  logic [3:0]             out_index_q, out_index_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [3:0]             index_inc_s;

  // Word mux over the shadow bank; only constant part-selects inside the loop
  function automatic logic [WIDTH-1:0] sel_word(input logic [NUM*WIDTH-1:0] bank,
                                                input logic [3:0]           idx);
    logic [WIDTH-1:0] word;
    word = {WIDTH{1'b0}};
    for (int i = 0; i < NUM; i++) begin
      word = (idx == 4'(i)) ? bank[i*WIDTH +: WIDTH] : word;
    end
    return word;
  endfunction

  assign index_inc_s = index_q + 4'd1;

  // Next-state and next-output decode; outputs are precomputed so they leave flops
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    shadow_d    = shadow_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          shadow_d    = Data_in;
          index_d     = 4'd0;
          state_d     = SEND;
          out_data_d  = Data_in[WIDTH-1:0];
          out_index_d = 4'd0;
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
        end else begin
          out_data_d  = {WIDTH{1'b0}};
          out_index_d = 4'd0;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      SEND: begin
        if (out_valid_q && Out_ready) begin
          if (index_q == LAST_IDX) begin
            state_d     = DONE;
            out_data_d  = {WIDTH{1'b0}};
            out_index_d = 4'd0;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            index_d     = index_inc_s;
            out_data_d  = sel_word(shadow_q, index_inc_s);
            out_index_d = index_inc_s;
          end
        end else begin
          state_d = SEND;
        end
      end
      DONE: begin
        state_d     = IDLE;
        out_data_d  = {WIDTH{1'b0}};
        out_index_d = 4'd0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
      default: begin
        state_d     = IDLE;
        index_d     = 4'd0;
        shadow_d    = {(NUM*WIDTH){1'b0}};
        out_data_d  = {WIDTH{1'b0}};
        out_index_d = 4'd0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State, shadow bank and output registers; a reset discards any transfer in flight
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      index_q     <= 4'd0;
      shadow_q    <= {(NUM*WIDTH){1'b0}};
      out_data_q  <= {WIDTH{1'b0}};
      out_index_q <= 4'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      shadow_q    <= shadow_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign Out_data  = out_data_q;
  assign Out_index = out_index_q;
  assign Out_valid = out_valid_q;
  assign Busy      = busy_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_result_reader.sv
// Directed bench for result_reader: outputs are packed as
// {Out_valid, Out_data, Out_index, Busy, Done} and compared at each falling edge.
module tb_result_reader;

  logic        CLK;
  logic        RESET;
  logic        Start;
  logic [23:0] Data_in;
  logic [7:0]  Out_data;
  logic [3:0]  Out_index;
  logic        Out_valid;
  logic        Out_ready;
  logic        Busy;
  logic        Done;

  int total = 0;
  int bad   = 0;

  result_reader #(.WIDTH(8), .NUM(3)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .Start     (Start),
    .Data_in   (Data_in),
    .Out_data  (Out_data),
    .Out_index (Out_index),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready),
    .Busy      (Busy),
    .Done      (Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [14:0] ex(input logic v, input logic [7:0] d,
                                     input logic [3:0] i, input logic b,
                                     input logic dn);
    return {v, d, i, b, dn};
  endfunction

  task automatic chk(input string tag, input logic [14:0] exp);
    logic [14:0] obs;
    obs = {Out_valid, Out_data, Out_index, Busy, Done};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  localparam logic [14:0] IDLE_O = 15'h0000;
  localparam logic [14:0] DONE_O = 15'h0003;

  initial begin
    RESET     = 1'b0;
    Start     = 1'b0;
    Out_ready = 1'b1;
    Data_in   = {8'h40, 8'h05, 8'hF0};

    // Reset asserted before any clock edge: outputs must already be 0
    #2;
    chk("reset_async", IDLE_O);
    @(negedge CLK);
    chk("reset_held", IDLE_O);
    RESET = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("idle_no_start", IDLE_O);
    end

    // Basic transfer, Out_ready held high
    Start = 1'b1;
    @(negedge CLK); Start = 1'b0;
    chk("basic_w0", ex(1'b1, 8'hF0, 4'd0, 1'b1, 1'b0));
    @(negedge CLK); chk("basic_w1", ex(1'b1, 8'h05, 4'd1, 1'b1, 1'b0));
    @(negedge CLK); chk("basic_w2", ex(1'b1, 8'h40, 4'd2, 1'b1, 1'b0));
    @(negedge CLK); chk("basic_done", DONE_O);
    @(negedge CLK); chk("basic_idle", IDLE_O);

    // Backpressure: word 1 held for three cycles
    Start = 1'b1;
    @(negedge CLK); Start = 1'b0;
    chk("bp_w0", ex(1'b1, 8'hF0, 4'd0, 1'b1, 1'b0));
    @(negedge CLK); chk("bp_w1_a", ex(1'b1, 8'h05, 4'd1, 1'b1, 1'b0));
    Out_ready = 1'b0;
    @(negedge CLK); chk("bp_w1_b", ex(1'b1, 8'h05, 4'd1, 1'b1, 1'b0));
    @(negedge CLK); chk("bp_w1_c", ex(1'b1, 8'h05, 4'd1, 1'b1, 1'b0));
    Out_ready = 1'b1;
    @(negedge CLK); chk("bp_w2", ex(1'b1, 8'h40, 4'd2, 1'b1, 1'b0));
    @(negedge CLK); chk("bp_done", DONE_O);
    @(negedge CLK); chk("bp_idle", IDLE_O);

    // Snapshot: Data_in changes after capture and Start pulses mid-transfer
    Start = 1'b1;
    @(negedge CLK); Start = 1'b0;
    chk("snap_w0", ex(1'b1, 8'hF0, 4'd0, 1'b1, 1'b0));
    Data_in = {8'hAA, 8'hAA, 8'hAA};
    Start   = 1'b1;
    @(negedge CLK); Start = 1'b0;
    chk("snap_w1", ex(1'b1, 8'h05, 4'd1, 1'b1, 1'b0));
    @(negedge CLK); chk("snap_w2", ex(1'b1, 8'h40, 4'd2, 1'b1, 1'b0));
    @(negedge CLK); chk("snap_done", DONE_O);
    @(negedge CLK); chk("snap_idle_a", IDLE_O);
    @(negedge CLK); chk("snap_idle_b", IDLE_O);

    // Reset in the middle of a transfer
    Data_in = {8'h40, 8'h05, 8'hF0};
    Start   = 1'b1;
    @(negedge CLK); Start = 1'b0;
    chk("rst_w0", ex(1'b1, 8'hF0, 4'd0, 1'b1, 1'b0));
    @(negedge CLK); chk("rst_w1", ex(1'b1, 8'h05, 4'd1, 1'b1, 1'b0));
    #1 RESET = 1'b0;
    #1 chk("rst_immediate", IDLE_O);
    #1 RESET = 1'b1;
    @(negedge CLK); chk("rst_no_done_a", IDLE_O);
    @(negedge CLK); chk("rst_no_done_b", IDLE_O);
    Data_in = {8'h33, 8'h22, 8'h11};
    Start   = 1'b1;
    @(negedge CLK); Start = 1'b0;
    chk("fresh_w0", ex(1'b1, 8'h11, 4'd0, 1'b1, 1'b0));
    @(negedge CLK); chk("fresh_w1", ex(1'b1, 8'h22, 4'd1, 1'b1, 1'b0));
    @(negedge CLK); chk("fresh_w2", ex(1'b1, 8'h33, 4'd2, 1'b1, 1'b0));
    @(negedge CLK); chk("fresh_done", DONE_O);

    // Back-to-back: Start during DONE is ignored, Start at the first idle edge is taken
    Data_in = {8'h40, 8'h05, 8'hF0};
    @(negedge CLK); chk("b2b_pre_idle", IDLE_O);
    Start = 1'b1;
    @(negedge CLK); Start = 1'b0;
    chk("b2b_w0", ex(1'b1, 8'hF0, 4'd0, 1'b1, 1'b0));
    @(negedge CLK); chk("b2b_w1", ex(1'b1, 8'h05, 4'd1, 1'b1, 1'b0));
    @(negedge CLK); chk("b2b_w2", ex(1'b1, 8'h40, 4'd2, 1'b1, 1'b0));
    @(negedge CLK); chk("b2b_done", DONE_O);
    Start = 1'b1;
    @(negedge CLK); chk("b2b_ignored", IDLE_O);
    Data_in = {8'h03, 8'h02, 8'h01};
    @(negedge CLK); Start = 1'b0;
    chk("b2b2_w0", ex(1'b1, 8'h01, 4'd0, 1'b1, 1'b0));
    @(negedge CLK); chk("b2b2_w1", ex(1'b1, 8'h02, 4'd1, 1'b1, 1'b0));
    @(negedge CLK); chk("b2b2_w2", ex(1'b1, 8'h03, 4'd2, 1'b1, 1'b0));
    @(negedge CLK); chk("b2b2_done", DONE_O);
    @(negedge CLK); chk("b2b2_idle", IDLE_O);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
